// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator slice.
package product_accumulator_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int LEN_W_DEF  = 8;

  // IDLE: no partial group held; ACCUM: a group is open in acc.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO, show-ahead: data_o is always the head entry.
module sync_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [1:0][W-1:0] mem_q;
  logic              wr_q, rd_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign data_o  = mem_q[rd_q];

  // A push on a full FIFO is dropped; upstream holds off before that happens.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; reset empties the FIFO and zeroes the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of acc_len signed products and queues each group sum in a
// 2-entry output FIFO.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ACC_W  = PROD_W + LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum,
  input  logic              sum_ready,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [ACC_W-1:0]   prod_ext, sum_next;
  logic               last, xfer, push;
  logic               fifo_empty, fifo_full;

  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // The next accepted product closes the group: L=1 at group start, or the
  // final outstanding product of an open group. acc_len=0 encodes 2^LEN_W,
  // and acc_len-1 wraps to 2^LEN_W-1, so the same decrement path covers it.
  assign last = (state_q == IDLE) ? (acc_len == LEN_W'(1)) : (rem_q == LEN_W'(1));

  // Only registered occupancy gates acceptance, never sum_ready, so there is
  // no combinational path from downstream accept to upstream ready.
  assign prod_ready = !clear && !(fifo_full && last);
  assign xfer       = prod_valid && prod_ready;
  assign sum_next   = (state_q == IDLE) ? prod_ext : acc_q + prod_ext;
  assign push       = xfer && last;
  assign busy       = (state_q == ACCUM);
  assign sum_valid  = !fifo_empty;

  // Group FSM: open on first product, count down, close and reset on last.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      rem_d   = '0;
    end else if (xfer) begin
      if (last) begin
        state_d = IDLE;
        acc_d   = '0;
        rem_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum_next;
        rem_d   = (state_q == IDLE) ? acc_len - LEN_W'(1) : rem_q - LEN_W'(1);
      end
    end
  end

  // Group state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  sync_fifo2 #(.W(ACC_W)) u_out_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (sum_next),
    .pop_i   (sum_ready),
    .data_o  (sum),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 64, the width of the signed product input from the sequential multiplier.
REQ-002 SHALL have parameter LEN_W, default 8, the width of the group-length field.
REQ-003 SHALL have parameter ACC_W, default PROD_W+LEN_W (72), the accumulator and sum width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1, a synchronous abort of the current group.
REQ-007 SHALL have port acc_len, input, LEN_W, the number of products per group; 0 means 2^LEN_W.
REQ-008 SHALL have port prod_valid, input, 1, which qualifies prod.
REQ-009 SHALL have port prod, input, PROD_W, a signed two's-complement product.
REQ-010 SHALL have port prod_ready, output, 1, which accepts prod when asserted together with prod_valid.
REQ-011 SHALL have port sum_valid, output, 1, which qualifies sum.
REQ-012 SHALL have port sum, output, ACC_W, the signed group sum.
REQ-013 SHALL have port sum_ready, input, 1, the downstream accept.
REQ-014 SHALL have port busy, output, 1, asserted while a group is partially accumulated.

Function
REQ-015 A product SHALL transfer only in a cycle where prod_valid=1 and prod_ready=1; likewise sum transfers only when sum_valid=1 and sum_ready=1.
REQ-016 The FSM SHALL have two states: IDLE (no partial group) and ACCUM (group open).
REQ-017 On a transfer in IDLE, the block SHALL latch the effective length L from acc_len, load acc with sign-extended prod, and set remaining to L-1; if L=1 it SHALL push directly to the output and stay in IDLE, otherwise it SHALL go to ACCUM.
REQ-018 On a transfer in ACCUM, the block SHALL compute acc + sign-extended prod; when remaining=1 it SHALL push that value, go to IDLE and clear acc, otherwise it SHALL decrement remaining.
REQ-019 acc_len SHALL be sampled only on the first product of a group; changes mid-group SHALL be ignored.
REQ-020 Arithmetic SHALL be full-width signed at ACC_W with no saturation; overflow is impossible for 2^LEN_W products.
REQ-021 The output SHALL be a 2-entry FIFO; sum_valid SHALL be !empty and sum SHALL be the head entry.
REQ-022 Latency SHALL be one cycle: sum_valid rises the cycle after the group's final product transfers, given an empty FIFO.
REQ-023 prod_ready SHALL be 0 when clear=1, or when the FIFO is full and the next transfer would complete a group (L=1 in IDLE, or remaining=1 in ACCUM); otherwise it SHALL be 1.
REQ-024 prod_ready SHALL depend only on registered FIFO occupancy, not on sum_ready in the same cycle.
REQ-025 A simultaneous push and pop on a 1-entry FIFO SHALL keep the occupancy at 1 and preserve order.
REQ-026 When clear=1, the block SHALL discard the partial group, go to IDLE and zero acc/remaining; FIFO contents and pops SHALL be unaffected.
REQ-027 busy SHALL be 1 exactly when state=ACCUM.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, acc=0, remaining=0, FIFO empty, sum_valid=0, sum=0 and busy=0.
REQ-029 prod_ready SHALL be 1 on the first cycle after reset release (when clear=0).
REQ-030 Reset mid-group or with a non-empty FIFO SHALL drop all data, and no sum SHALL emerge afterwards.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, ACCUM) and the default PROD_W/LEN_W constants.
REQ-032 The output FIFO SHALL be a separate sub-module, sync_fifo2, parameterised on width.

Verification
REQ-033 Verification SHALL cover: acc_len=3, prods 5, -7, 10 back-to-back, sum_ready=1 -> sum=8 one cycle after the third product, and busy=1 for 2 cycles.
REQ-034 Verification SHALL cover: acc_len=1, prod=-(2^63), sum_ready=0 for 3 groups -> two sums queued, then prod_ready=0 for the third; release sum_ready -> sums pop in order, each -2^63 sign-extended.
REQ-035 Verification SHALL cover: acc_len=0, 256 products of 2^63-1 -> sum=256*(2^63-1) with no wrap.
REQ-036 Verification SHALL cover: acc_len=4, 2 products, then clear with prod_valid=1 -> product not accepted, busy=0; the next 4 products (1,1,1,1) -> sum=4.
REQ-037 Verification SHALL cover: acc_len changed from 4 to 2 after the first product -> the group still completes after 4 products.
REQ-038 Verification SHALL cover: reset_n asserted mid-group with 1 FIFO entry -> sum_valid=0 immediately, and no stale sum after release.
